toy_bus_arb_node_lsu_req_rr: RTL
================================

# toy_bus_arb_node_lsu_req_rr

Round-robin arbiter that merges three ToyBusReq requester ports onto one downstream ToyBusReq port through a registered output stage. It sits in front of a shared bus node, such as the LSU request decoder input, and sequences competing masters onto that single channel. The arbitration is fair and the block sustains one beat per cycle. It also reports which port won, so responses can be routed back.

## Interface
Parameters:
- N_IN, 3, number of requester ports (fixed at 3 in this build)
- ADDR_W, 32, address width
- STRB_W, 32, byte-strobe width
- DATA_W, 256, data width
- ID_W, 4, src/tgt id width
- SB_W, 32, sideband width

Ports (timing is decided: one clock; reset is asynchronous and active-high):
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in{i}_vld  in  1  request valid, i=0..2
- in{i}_rdy  out  1  request accepted this cycle
- in{i}_addr  in  ADDR_W  address
- in{i}_strb  in  STRB_W  byte strobes
- in{i}_data  in  DATA_W  write data
- in{i}_opcode  in  1  opcode
- in{i}_src_id  in  ID_W  source id
- in{i}_tgt_id  in  ID_W  target id
- in{i}_sideband  in  SB_W  sideband
- out0_vld  out  1  registered request valid
- out0_rdy  in  1  downstream ready
- out0_addr, out0_strb, out0_data, out0_opcode, out0_src_id, out0_tgt_id, out0_sideband  out  same widths  registered payload
- out0_port  out  2  index of the winning input for the held beat

## Operation
- Output register `ob`:
  - Fields: `ob_vld`, payload, `ob_port`.
  - Drives the out0_* ports directly.
- Load enable is `load = !ob_vld || out0_rdy`. This makes the register a full-throughput pipeline stage.
- Round-robin pointer `ptr` (2 bits, values 0..2):
  - On each cycle, search order is `ptr`, `ptr+1`, `ptr+2` (mod 3).
  - The first asserted `in{i}_vld` in that order is the winner `g`.
- Readiness:
  - `in{g}_rdy = load`.
  - Every other `in_rdy` is 0.
  - With no valid input, all `in_rdy` are 0.
  - `in_rdy` may depend combinationally on `in_vld` and `out0_rdy`.
- On a handshake (`in{g}_vld && in{g}_rdy`):
  - Payload of g is captured into `ob`.
  - `ob_vld` is set to 1.
  - `ob_port` is set to g.
  - `ptr` is set to (g+1) mod 3.
- When `load` is true and no input is valid:
  - `ob_vld` is set to 0.
  - Payload holds its last value.
  - `ptr` holds.
- When `ob_vld && !out0_rdy`:
  - `ob` holds every field unchanged.
  - No input is accepted.
- Payload passes through unmodified; the arbiter does no decoding of tgt_id.
- Upstream rule: once `in{i}_vld` rises, it must stay high with stable payload until the handshake. The arbiter does not depend on this for correctness.
- `ptr` wrap: 2 goes to 0. The value 3 is unreachable; if it ever occurs, treat it as 0.

## Timing
- Reset values (asynchronous, applied while `rst`=1):
  - `ob_vld`=0, so `out0_vld`=0.
  - All out0 payload bits = 0.
  - `out0_port`=0.
  - `ptr`=0.
  - All `in_rdy` = 0 during reset, because `ob_vld`=0 but `rst` gates them.
- Latency: a request accepted in cycle N appears on `out0_vld` in cycle N+1.
- Throughput: 1 beat/cycle when `out0_rdy` is held high.
- Back-to-back behaviour: when `out0_rdy`=1 and `ob_vld`=1, the current beat retires and a new winner loads in the same cycle.
- Simultaneous requests are granted in strict rotation. Any requester waits at most 2 grants.
- Reset mid-operation: the held beat is dropped with no handshake, and `ptr` returns to 0.
- First cycle after reset deassertion: normal arbitration, with port 0 highest priority.

## Structure
- Shared package `toy_bus_pkg`, containing:
  - ToyBusReq field widths (`ADDR_W`, `STRB_W`, `DATA_W`, `ID_W`, `SB_W`)
  - `N_IN`
  - the port-index width
- Sub-module `toy_bus_rr_pick`, purely combinational:
  - inputs: vld vector[2:0], `ptr`
  - outputs: one-hot grant[2:0], any, index g
- The top module holds:
  - the `ptr` register
  - the `ob` register
  - the payload mux (one-hot AND-OR over grant)

## Test plan
- **Reset:** assert `rst` with all `in_vld`=1 → `out0_vld`=0, all `in_rdy`=0, `out0_port`=0. After release, first grant goes to port 0.
- **Round-robin rotation:** in0/1/2 all valid continuously with tgt_id 2/3/4, `out0_rdy`=1 → `out0_port` sequence is 0,1,2,0,1,2. `out0_tgt_id` follows 2,3,4 with 1-cycle latency.
- **Backpressure:**
  - Stimulus: in1 only, addr=0x1000; `out0_rdy`=0 for 3 cycles.
  - Response: `out0_vld`=1 and addr=0x1000 held stable; `in1_rdy`=0 while stalled.
  - On `out0_rdy`=1, retire, and a new in1 beat (addr=0x1004) loads in the same cycle.
- **Pointer skip:** `ptr`=1 with only in0 and in2 valid → in2 wins, `ptr` becomes 0, and the next grant goes to in0.
- **Idle bubble:** all `in_vld`=0 with `out0_rdy`=1 → `out0_vld` drops to 0 the next cycle, and `ptr` is unchanged.
- **Mid-stall reset:** `rst` pulsed while `ob_vld`=1, `out0_rdy`=0 → `out0_vld`=0 immediately (async), and `ptr`=0.

Source files
------------

// File: rtl/toy_bus_pkg.sv
// Shared ToyBusReq widths, request payload struct and port-index helpers
// for the LSU request arbitration node.
package toy_bus_pkg;

  localparam int unsigned N_IN   = 3;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned STRB_W = 32;
  localparam int unsigned DATA_W = 256;
  localparam int unsigned ID_W   = 4;
  localparam int unsigned SB_W   = 32;
  localparam int unsigned PORT_W = 2;

  typedef logic [PORT_W-1:0] port_idx_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [STRB_W-1:0] strb;
    logic [DATA_W-1:0] data;
    logic              opcode;
    logic [ID_W-1:0]   src_id;
    logic [ID_W-1:0]   tgt_id;
    logic [SB_W-1:0]   sideband;
  } req_t;

  localparam int unsigned REQ_W = $bits(req_t);

  // Next port in rotation; the last port and the unreachable index 3 both wrap to 0.
  function automatic port_idx_t port_inc(port_idx_t p);
    return (p >= port_idx_t'(N_IN - 1)) ? '0 : p + port_idx_t'(1);
  endfunction

endpackage

// File: rtl/toy_bus_arb_node_lsu_req_rr_if.sv
// ToyBusReq valid/ready channel; master drives the request, slave returns ready.
interface toy_bus_arb_node_lsu_req_rr_if import toy_bus_pkg::*; ();

  logic              vld;
  logic              rdy;
  logic [ADDR_W-1:0] addr;
  logic [STRB_W-1:0] strb;
  logic [DATA_W-1:0] data;
  logic              opcode;
  logic [ID_W-1:0]   src_id;
  logic [ID_W-1:0]   tgt_id;
  logic [SB_W-1:0]   sideband;

  modport master (
    output vld, addr, strb, data, opcode, src_id, tgt_id, sideband,
    input  rdy
  );

  modport slave (
    input  vld, addr, strb, data, opcode, src_id, tgt_id, sideband,
    output rdy
  );

endinterface

// File: rtl/toy_bus_rr_pick.sv
// Combinational round-robin picker: first valid requester searching from ptr upward (mod N_IN).
module toy_bus_rr_pick import toy_bus_pkg::*; (
  input  logic [N_IN-1:0] vld,
  input  port_idx_t       ptr,
  output logic [N_IN-1:0] grant,
  output logic            any,
  output port_idx_t       idx
);

  port_idx_t   start;
  port_idx_t   cand;
  int unsigned c;

  always_comb begin
    grant = '0;
    any   = 1'b0;
    idx   = '0;
    cand  = '0;
    c     = 0;
    start = (ptr >= port_idx_t'(N_IN)) ? '0 : ptr;
    for (int unsigned k = 0; k < N_IN; k++) begin
      c = 32'(start) + k;
      if (c >= N_IN) c = c - N_IN;
      cand = port_idx_t'(c);
      if (!any && vld[cand]) begin
        grant[cand] = 1'b1;
        any         = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/toy_bus_arb_node_lsu_req_rr.sv
// Three-to-one round-robin arbiter for ToyBusReq with a registered, full-throughput
// output stage and a winning-port tag for response routing.
module toy_bus_arb_node_lsu_req_rr import toy_bus_pkg::*; (
  input  logic                                clk,
  input  logic                                rst,
  toy_bus_arb_node_lsu_req_rr_if.slave        in0,
  toy_bus_arb_node_lsu_req_rr_if.slave        in1,
  toy_bus_arb_node_lsu_req_rr_if.slave        in2,
  toy_bus_arb_node_lsu_req_rr_if.master       out0,
  output port_idx_t                           out0_port
);

  logic [N_IN-1:0]  vld_vec;
  logic [N_IN-1:0]  grant;
  logic             any;
  port_idx_t        g;
  port_idx_t        ptr;
  logic             load;
  req_t             pl [N_IN];
  logic [REQ_W-1:0] mux_bits;

  logic             ob_vld;
  req_t             ob_pl;
  port_idx_t        ob_port;

  assign vld_vec = {in2.vld, in1.vld, in0.vld};

  assign pl[0] = '{addr: in0.addr, strb: in0.strb, data: in0.data, opcode: in0.opcode,
                   src_id: in0.src_id, tgt_id: in0.tgt_id, sideband: in0.sideband};
  assign pl[1] = '{addr: in1.addr, strb: in1.strb, data: in1.data, opcode: in1.opcode,
                   src_id: in1.src_id, tgt_id: in1.tgt_id, sideband: in1.sideband};
  assign pl[2] = '{addr: in2.addr, strb: in2.strb, data: in2.data, opcode: in2.opcode,
                   src_id: in2.src_id, tgt_id: in2.tgt_id, sideband: in2.sideband};

  toy_bus_rr_pick u_pick (
    .vld   (vld_vec),
    .ptr   (ptr),
    .grant (grant),
    .any   (any),
    .idx   (g)
  );

  always_comb begin
    mux_bits = (pl[0] & {REQ_W{grant[0]}})
             | (pl[1] & {REQ_W{grant[1]}})
             | (pl[2] & {REQ_W{grant[2]}});
  end

  assign load = !ob_vld || out0.rdy;

  // rst gates ready so no upstream handshake is seen while the stage is held in reset.
  assign in0.rdy = grant[0] & load & ~rst;
  assign in1.rdy = grant[1] & load & ~rst;
  assign in2.rdy = grant[2] & load & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ob_vld  <= 1'b0;
      ob_pl   <= '0;
      ob_port <= '0;
      ptr     <= '0;
    end else if (load) begin
      if (any) begin
        ob_vld  <= 1'b1;
        ob_pl   <= req_t'(mux_bits);
        ob_port <= g;
        ptr     <= port_inc(g);
      end else begin
        ob_vld  <= 1'b0;
      end
    end
  end

  assign out0.vld      = ob_vld;
  assign out0.addr     = ob_pl.addr;
  assign out0.strb     = ob_pl.strb;
  assign out0.data     = ob_pl.data;
  assign out0.opcode   = ob_pl.opcode;
  assign out0.src_id   = ob_pl.src_id;
  assign out0.tgt_id   = ob_pl.tgt_id;
  assign out0.sideband = ob_pl.sideband;
  assign out0_port     = ob_port;

endmodule
